// File: rtl/fpu_ss_wb_arbiter.sv
// FPR write-port arbiter between FPnew results and memory load results.
// Loads have priority; a starving FPU result can override once the load buffer has room.
module fpu_ss_wb_arbiter #(
  parameter int FLEN          = 32,
  parameter int MEM_BUF_DEPTH = 2,
  parameter int MAX_STARVE    = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            fpu_wb_valid_i,
  output logic            fpu_wb_ready_o,
  input  logic [4:0]      fpu_wb_addr_i,
  input  logic [FLEN-1:0] fpu_wb_data_i,
  input  logic            mem_wb_valid_i,
  input  logic            mem_wb_we_i,
  input  logic [4:0]      mem_wb_addr_i,
  input  logic [FLEN-1:0] mem_wb_data_i,
  output logic            fpr_we_o,
  output logic [4:0]      fpr_waddr_o,
  output logic [FLEN-1:0] fpr_wdata_o,
  output logic            wb_src_o,
  output logic [2:0]      mem_buf_cnt_o,
  output logic            mem_buf_full_o
);

  localparam int SW = $clog2(MAX_STARVE + 1);
  localparam logic [2:0]    DEPTH_C      = 3'(MEM_BUF_DEPTH);
  localparam logic [SW-1:0] STARVE_MAX_C = SW'(MAX_STARVE);

  // Shift-register FIFO: entry 0 is always the head.
  logic [4:0]      r_buf_addr [MEM_BUF_DEPTH];
  logic [FLEN-1:0] r_buf_data [MEM_BUF_DEPTH];
  logic [4:0]      w_nxt_addr [MEM_BUF_DEPTH];
  logic [FLEN-1:0] w_nxt_data [MEM_BUF_DEPTH];
  logic [2:0]      r_cnt;
  logic [2:0]      w_cnt_nxt;
  logic [2:0]      w_tail;
  logic [SW-1:0]   r_starve;

  logic w_in_load;
  logic w_mem_pending;
  logic w_override;
  logic w_fpu_grant;
  logic w_mem_grant;
  logic w_pop;
  logic w_push;

  assign w_in_load      = mem_wb_valid_i & mem_wb_we_i;
  assign w_mem_pending  = (r_cnt != 3'd0) | w_in_load;
  assign w_override     = (r_starve == STARVE_MAX_C) & (r_cnt < DEPTH_C);
  assign fpu_wb_ready_o = ~w_mem_pending | w_override;
  assign w_fpu_grant    = fpu_wb_valid_i & fpu_wb_ready_o;
  assign w_mem_grant    = w_mem_pending & ~w_override;
  assign w_pop          = w_mem_grant & (r_cnt != 3'd0);
  // The incoming load is consumed only when it bypasses an empty buffer.
  assign w_push         = w_in_load & ~(w_mem_grant & (r_cnt == 3'd0));

  assign mem_buf_cnt_o  = r_cnt;
  assign mem_buf_full_o = (r_cnt == DEPTH_C);

  always_comb begin
    fpr_we_o    = 1'b0;
    wb_src_o    = 1'b0;
    fpr_waddr_o = 5'd0;
    fpr_wdata_o = '0;
    if (w_fpu_grant) begin
      fpr_we_o    = 1'b1;
      fpr_waddr_o = fpu_wb_addr_i;
      fpr_wdata_o = fpu_wb_data_i;
    end else if (w_mem_grant) begin
      fpr_we_o = 1'b1;
      wb_src_o = 1'b1;
      if (r_cnt != 3'd0) begin
        fpr_waddr_o = r_buf_addr[0];
        fpr_wdata_o = r_buf_data[0];
      end else begin
        fpr_waddr_o = mem_wb_addr_i;
        fpr_wdata_o = mem_wb_data_i;
      end
    end
  end

  always_comb begin
    w_nxt_addr = r_buf_addr;
    w_nxt_data = r_buf_data;
    if (w_pop) begin
      for (int i = 0; i < MEM_BUF_DEPTH - 1; i++) begin
        w_nxt_addr[i] = r_buf_addr[i+1];
        w_nxt_data[i] = r_buf_data[i+1];
      end
    end
    // Tail slot is computed after the shift so pop+push at full keeps order.
    w_tail = r_cnt - {2'b00, w_pop};
    for (int i = 0; i < MEM_BUF_DEPTH; i++) begin
      if (w_push && (w_tail == 3'(i))) begin
        w_nxt_addr[i] = mem_wb_addr_i;
        w_nxt_data[i] = mem_wb_data_i;
      end
    end
    w_cnt_nxt = r_cnt + {2'b00, w_push} - {2'b00, w_pop};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt    <= 3'd0;
      r_starve <= '0;
      for (int i = 0; i < MEM_BUF_DEPTH; i++) begin
        r_buf_addr[i] <= 5'd0;
        r_buf_data[i] <= '0;
      end
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_buf_addr <= w_nxt_addr;
      r_buf_data <= w_nxt_data;
      if (fpu_wb_valid_i && !fpu_wb_ready_o) begin
        if (r_starve != STARVE_MAX_C) r_starve <= r_starve + 1'b1;
      end else begin
        r_starve <= '0;
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(w_push && !w_pop && (r_cnt == DEPTH_C)));

endmodule

// File: tb/tb_fpu_ss_wb_arbiter.sv
// Directed bench for fpu_ss_wb_arbiter: driver pushes expected per-cycle outputs,
// a negedge monitor pops and compares them.
module tb_fpu_ss_wb_arbiter;

  localparam int FLEN = 32;
  localparam int EW   = 1 + 1 + 5 + FLEN + 1 + 3 + 1;

  logic            clk;
  logic            rst_n;
  logic            fpu_wb_valid;
  logic            fpu_wb_ready;
  logic [4:0]      fpu_wb_addr;
  logic [FLEN-1:0] fpu_wb_data;
  logic            mem_wb_valid;
  logic            mem_wb_we;
  logic [4:0]      mem_wb_addr;
  logic [FLEN-1:0] mem_wb_data;
  logic            fpr_we;
  logic [4:0]      fpr_waddr;
  logic [FLEN-1:0] fpr_wdata;
  logic            wb_src;
  logic [2:0]      mem_buf_cnt;
  logic            mem_buf_full;

  logic [EW-1:0] exp_q[$];
  string         name_q[$];
  int            n_checks = 0;
  int            n_errors = 0;

  fpu_ss_wb_arbiter #(.FLEN(FLEN), .MEM_BUF_DEPTH(2), .MAX_STARVE(2)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .fpu_wb_valid_i (fpu_wb_valid),
    .fpu_wb_ready_o (fpu_wb_ready),
    .fpu_wb_addr_i  (fpu_wb_addr),
    .fpu_wb_data_i  (fpu_wb_data),
    .mem_wb_valid_i (mem_wb_valid),
    .mem_wb_we_i    (mem_wb_we),
    .mem_wb_addr_i  (mem_wb_addr),
    .mem_wb_data_i  (mem_wb_data),
    .fpr_we_o       (fpr_we),
    .fpr_waddr_o    (fpr_waddr),
    .fpr_wdata_o    (fpr_wdata),
    .wb_src_o       (wb_src),
    .mem_buf_cnt_o  (mem_buf_cnt),
    .mem_buf_full_o (mem_buf_full)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: apply one cycle of inputs and queue the outputs expected in that cycle.
  task automatic drive(input string nm, input logic rst,
                       input logic fv, input logic [4:0] fa, input logic [FLEN-1:0] fd,
                       input logic mv, input logic mwe, input logic [4:0] ma, input logic [FLEN-1:0] md,
                       input logic e_we, input logic e_src, input logic [4:0] e_addr,
                       input logic [FLEN-1:0] e_data, input logic e_rdy,
                       input logic [2:0] e_cnt, input logic e_full);
    rst_n        = rst;
    fpu_wb_valid = fv;
    fpu_wb_addr  = fa;
    fpu_wb_data  = fd;
    mem_wb_valid = mv;
    mem_wb_we    = mwe;
    mem_wb_addr  = ma;
    mem_wb_data  = md;
    exp_q.push_back({e_we, e_src, e_addr, e_data, e_rdy, e_cnt, e_full});
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string nm, input logic rst);
    drive(nm, rst, 0, 5'd0, 32'h0, 0, 0, 5'd0, 32'h0, 0, 0, 5'd0, 32'h0, 1, 3'd0, 0);
  endtask

  // Load to addr a with data 0x100+a while FPU op (fa, fd) is held valid.
  task automatic ld_fpu(input string nm, input logic [4:0] fa, input logic [FLEN-1:0] fd,
                        input logic [4:0] la,
                        input logic e_src, input logic [4:0] e_addr, input logic [FLEN-1:0] e_data,
                        input logic e_rdy, input logic [2:0] e_cnt, input logic e_full);
    drive(nm, 1, 1, fa, fd, 1, 1, la, 32'h100 + {27'd0, la},
          1, e_src, e_addr, e_data, e_rdy, e_cnt, e_full);
  endtask

  // Scoreboard monitor
  initial begin
    logic [EW-1:0] act;
    logic [EW-1:0] exp;
    string         nm;
    forever begin
      @(negedge clk);
      act = {fpr_we, wb_src, fpr_waddr, fpr_wdata, fpu_wb_ready, mem_buf_cnt, mem_buf_full};
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        nm  = name_q.pop_front();
        n_checks++;
        if (act !== exp) begin
          n_errors++;
          $display("FAIL %s: got we=%b src=%b addr=%0d data=%h rdy=%b cnt=%0d full=%b, want we=%b src=%b addr=%0d data=%h rdy=%b cnt=%0d full=%b",
                   nm, act[EW-1], act[EW-2], act[EW-3 -: 5], act[EW-8 -: FLEN], act[4], act[3:1], act[0],
                   exp[EW-1], exp[EW-2], exp[EW-3 -: 5], exp[EW-8 -: FLEN], exp[4], exp[3:1], exp[0]);
        end
      end else if (fpr_we) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: got we=1 addr=%0d, want no write", fpr_waddr);
      end
    end
  end

  initial begin
    int wait_cyc;
    rst_n = 1'b0;
    fpu_wb_valid = 0; fpu_wb_addr = 0; fpu_wb_data = 0;
    mem_wb_valid = 0; mem_wb_we = 0; mem_wb_addr = 0; mem_wb_data = 0;
    @(posedge clk);
    #1;
    idle("reset0", 0);
    idle("reset1", 0);
    idle("post_reset_idle", 1);

    // FPU alone: same-cycle write.
    drive("fpu_only", 1, 1, 5'd3, 32'h3F800000, 0, 0, 5'd0, 32'h0,
          1, 0, 5'd3, 32'h3F800000, 1, 3'd0, 0);
    idle("idle_a", 1);

    // FPU and load together: load first, FPU next cycle.
    drive("collide_load", 1, 1, 5'd1, 32'h11111111, 1, 1, 5'd2, 32'h22222222,
          1, 1, 5'd2, 32'h22222222, 0, 3'd0, 0);
    drive("collide_fpu", 1, 1, 5'd1, 32'h11111111, 0, 0, 5'd0, 32'h0,
          1, 0, 5'd1, 32'h11111111, 1, 3'd0, 0);

    // Starvation override with MAX_STARVE=2.
    ld_fpu("starve_ld4", 5'd7, 32'hAAAA0007, 5'd4, 1, 5'd4, 32'h104, 0, 3'd0, 0);
    ld_fpu("starve_ld5", 5'd7, 32'hAAAA0007, 5'd5, 1, 5'd5, 32'h105, 0, 3'd0, 0);
    ld_fpu("override",   5'd7, 32'hAAAA0007, 5'd6, 0, 5'd7, 32'hAAAA0007, 1, 3'd0, 0);
    drive("drain_ld6", 1, 0, 5'd0, 32'h0, 0, 0, 5'd0, 32'h0,
          1, 1, 5'd6, 32'h106, 0, 3'd1, 0);
    idle("idle_c", 1);

    // Store responses never write and never block the FPU.
    drive("store_idle", 1, 0, 5'd0, 32'h0, 1, 0, 5'd9, 32'hDEAD0000,
          0, 0, 5'd0, 32'h0, 1, 3'd0, 0);
    drive("store_fpu", 1, 1, 5'd2, 32'h00001234, 1, 0, 5'd9, 32'hDEAD0000,
          1, 0, 5'd2, 32'h00001234, 1, 3'd0, 0);

    // Fill the buffer through two overrides, then stream loads at full.
    ld_fpu("fill_ld10", 5'd9, 32'h99, 5'd10, 1, 5'd10, 32'h10A, 0, 3'd0, 0);
    ld_fpu("fill_ld11", 5'd9, 32'h99, 5'd11, 1, 5'd11, 32'h10B, 0, 3'd0, 0);
    ld_fpu("fill_ovr1", 5'd9, 32'h99, 5'd12, 0, 5'd9,  32'h99,  1, 3'd0, 0);
    ld_fpu("fill_ld13", 5'd8, 32'h88, 5'd13, 1, 5'd12, 32'h10C, 0, 3'd1, 0);
    ld_fpu("fill_ld14", 5'd8, 32'h88, 5'd14, 1, 5'd13, 32'h10D, 0, 3'd1, 0);
    ld_fpu("fill_ovr2", 5'd8, 32'h88, 5'd15, 0, 5'd8,  32'h88,  1, 3'd1, 0);
    ld_fpu("full_ld16", 5'd5, 32'h5555, 5'd16, 1, 5'd14, 32'h10E, 0, 3'd2, 1);
    ld_fpu("full_ld17", 5'd5, 32'h5555, 5'd17, 1, 5'd15, 32'h10F, 0, 3'd2, 1);
    ld_fpu("full_no_ovr18", 5'd5, 32'h5555, 5'd18, 1, 5'd16, 32'h110, 0, 3'd2, 1);
    ld_fpu("full_no_ovr19", 5'd5, 32'h5555, 5'd19, 1, 5'd17, 32'h111, 0, 3'd2, 1);

    // Reset with two buffered loads: discarded, no write.
    idle("reset_full", 0);
    idle("after_reset", 1);
    drive("fpu_after_reset", 1, 1, 5'd30, 32'hC0000000, 0, 0, 5'd0, 32'h0,
          1, 0, 5'd30, 32'hC0000000, 1, 3'd0, 0);
    idle("final_idle", 1);

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout: got %0d pending, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fpu_ss_wb_arbiter.md
FPU_SS_WB_ARBITER -- requirements
Module: fpu_ss_wb_arbiter

Interface
REQ-001 Parameter FLEN, default 32: FP register data width.
REQ-002 Parameter MEM_BUF_DEPTH, default 2 (range 1..4): load-result buffer entries.
REQ-003 Parameter MAX_STARVE, default 4 (>=1): consecutive FPU-blocked cycles before FPU override.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low. Ports are clk_i and rst_ni.
REQ-005 clk_i  in  1  clock.
REQ-006 rst_ni  in  1  async active-low reset.
REQ-007 fpu_wb_valid_i  in  1  FPnew result valid with FP destination.
REQ-008 fpu_wb_ready_o  out  1  FPnew result accepted this cycle.
REQ-009 fpu_wb_addr_i  in  5  FPnew destination FPR.
REQ-010 fpu_wb_data_i  in  FLEN  FPnew result.
REQ-011 mem_wb_valid_i  in  1  memory result valid; no backpressure possible.
REQ-012 mem_wb_we_i  in  1  memory result writes an FPR (load); 0 = store response.
REQ-013 mem_wb_addr_i  in  5  load destination FPR.
REQ-014 mem_wb_data_i  in  FLEN  load data.
REQ-015 fpr_we_o  out  1  FPR write-port enable.
REQ-016 fpr_waddr_o  out  5  FPR write address.
REQ-017 fpr_wdata_o  out  FLEN  FPR write data.
REQ-018 wb_src_o  out  1  0 = FPU write, 1 = memory write; valid when fpr_we_o=1.
REQ-019 mem_buf_cnt_o  out  3  buffered load results.
REQ-020 mem_buf_full_o  out  1  mem_buf_cnt_o == MEM_BUF_DEPTH; controller blocks new load issue.

Function
REQ-021 Memory results with mem_wb_we_i=0 SHALL be ignored entirely.
REQ-022 mem_pending = (mem_buf_cnt_o != 0) | (mem_wb_valid_i & mem_wb_we_i).
REQ-023 override = (starve_cnt == MAX_STARVE) & (mem_buf_cnt_o < MEM_BUF_DEPTH).
REQ-024 fpu_wb_ready_o = ~mem_pending | override; combinational, zero latency.
REQ-025 FPU grant (fpu_wb_valid_i & fpu_wb_ready_o): fpr_we_o=1, wb_src_o=0, address/data from FPU inputs in the same cycle.
REQ-026 Memory grant (mem_pending & ~override): fpr_we_o=1, wb_src_o=1; source is the buffer head if non-empty, else the incoming result (bypass, zero latency).
REQ-027 Buffer is FIFO; an incoming load result not written this cycle SHALL be pushed at the tail.
REQ-028 Simultaneous pop and push SHALL leave the count unchanged and preserve order, including at count == MEM_BUF_DEPTH.
REQ-029 Push into a full buffer without a same-cycle pop cannot occur by construction; an SVA assertion SHALL flag it.
REQ-030 starve_cnt (width clog2(MAX_STARVE+1)) SHALL increment, saturating at MAX_STARVE, each cycle fpu_wb_valid_i=1 and fpu_wb_ready_o=0.
REQ-031 starve_cnt SHALL clear on an FPU grant or when fpu_wb_valid_i=0.
REQ-032 Exactly one FPR write per cycle at most; with nothing pending, fpr_we_o=0 and address/data SHALL be 0.
REQ-033 The FPU source holds valid/addr/data stable until accepted; the block need not tolerate withdrawal.

Reset
REQ-034 On rst_ni=0: buffer empty, mem_buf_cnt_o=0, mem_buf_full_o=0, starve_cnt=0, fpr_we_o=0, wb_src_o=0, fpu_wb_ready_o=1.
REQ-035 Reset mid-operation SHALL discard buffered results without any write; the first post-reset cycle behaves as REQ-034.

Verification
REQ-036 Idle, FPU valid addr=3 data=0x3F800000 -> same cycle fpr_we_o=1, waddr=3, wdata=0x3F800000, wb_src_o=0, ready=1.
REQ-037 FPU valid (addr 1) and load (addr 2, we=1) in the same cycle -> load written (src=1), FPU ready=0, next cycle FPU written, count stays 0.
REQ-038 Loads to addr 4,5,6 on consecutive cycles with FPU held valid, MAX_STARVE=2 -> writes 4,5 (src=1), then FPU (override) with load 6 buffered (count=1), then 6; FPR write order matches FIFO order.
REQ-039 MEM_BUF_DEPTH=2: buffer full plus incoming load -> pop+push, count stays 2, full=1, FPU ready=0 even at starve_cnt == MAX_STARVE.
REQ-040 Store response (valid=1, we=0) while idle -> fpr_we_o=0, count=0, FPU ready unaffected.
REQ-041 Assert rst_ni with count=2 -> count=0, no write issued, fpu_wb_ready_o=1 immediately.
